fifo_arbiter: RTL and testbench

Round-robin write arbiter and guard controller that shares one `fifo` instance among `NUM_REQ` producers and one consumer. Each cycle it grants at most one requesting producer a write slot and suppresses writes when full and reads when empty, so the shared `fifo` never overflows or underflows. It tracks occupancy itself and raises a sticky error when a read is requested on an empty buffer.

---
 rtl/fifo_arbiter_pkg.sv | 34 +++
 rtl/fifo.sv | 44 ++++
 rtl/fifo_arbiter.sv | 99 +++++++++
 tb/tb_fifo_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_arbiter_pkg.sv
// Shared types and the round-robin pick helper for the fifo_arbiter slice.
package fifo_arbiter_pkg;

    localparam int DEF_NUM_REQ    = 4;
    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_ADDR_WIDTH = 3;
    localparam int MAX_REQ        = 8;
    localparam int IDX_W          = 3;

    typedef logic [DEF_ADDR_WIDTH:0] count_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // First set bit of req scanning upward from ptr, wrapping modulo n (n <= MAX_REQ).
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] req,
                                      input logic [IDX_W-1:0]   ptr,
                                      input int                 n);
        pick_t p;
        int    idx;
        p = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = (int'(ptr) + k) % n;
            if (k < n && !p.valid && req[idx[IDX_W-1:0]]) begin
                p.valid = 1'b1;
                p.idx   = idx[IDX_W-1:0];
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/fifo.sv
// Show-ahead synchronous FIFO: r_data presents the head word while not empty.
module fifo #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic                  rd,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;

    always_ff @(posedge clk) begin
        if (wr) begin
            r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= w_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Extra pointer bit separates the wrapped-full case from empty.
    assign r_data = r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
    assign empty  = (r_wr_ptr == r_rd_ptr);
    assign full   = (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]) &&
                    (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]);

endmodule

// File: rtl/fifo_arbiter.sv
// Round-robin write arbiter in front of one shared fifo; guards against
// overflow/underflow using its own occupancy count.
module fifo_arbiter
    import fifo_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          rd,
    output logic [DATA_WIDTH-1:0]         r_data,
    output logic                          empty,
    output logic                          full,
    output logic [ADDR_WIDTH:0]           count,
    output logic                          err_underflow
);

    localparam int                  DEPTH   = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);

    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_err;
    logic [IDX_W-1:0]      r_rr_ptr;

    logic [MAX_REQ-1:0]    w_req_ext;
    pick_t                 w_pick;
    logic                  w_rd_ok;
    logic                  w_wr_ok;
    logic                  w_wr;
    logic [IDX_W-1:0]      w_ptr_next;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  w_reset;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;

    assign w_req_ext = MAX_REQ'(req);
    assign w_pick    = rr_pick(w_req_ext, r_rr_ptr, NUM_REQ);

    assign empty   = (r_count == '0);
    assign full    = (r_count == DEPTH_C);
    assign w_rd_ok = rd & ~empty;
    // A same-cycle pop frees the slot the write needs.
    assign w_wr_ok = ~full | w_rd_ok;
    assign w_wr    = reset_n & w_wr_ok & w_pick.valid;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_gnt
            assign gnt[gi] = w_wr && (w_pick.idx == IDX_W'(gi));
        end
    endgenerate

    assign w_data     = req_data[w_pick.idx*DATA_WIDTH +: DATA_WIDTH];
    assign w_ptr_next = (w_pick.idx == IDX_W'(NUM_REQ-1)) ? '0 : w_pick.idx + 1'b1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count  <= '0;
            r_err    <= 1'b0;
            r_rr_ptr <= '0;
        end else begin
            if (w_wr) r_rr_ptr <= w_ptr_next;
            if (rd & empty) r_err <= 1'b1;
            case ({w_wr, w_rd_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign count         = r_count;
    assign err_underflow = r_err;
    assign w_reset       = ~reset_n;

    fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_fifo (
        .clk    (clk),
        .reset  (w_reset),
        .wr     (w_wr),
        .w_data (w_data),
        .rd     (w_rd_ok),
        .r_data (r_data),
        .full   (w_fifo_full),
        .empty  (w_fifo_empty)
    );

    a_gnt_onehot0: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(gnt));
    a_count_range: assert property (@(posedge clk) disable iff (!reset_n) r_count <= DEPTH_C);
    a_full_match:  assert property (@(posedge clk) disable iff (!reset_n) w_fifo_full == full);
    a_empty_match: assert property (@(posedge clk) disable iff (!reset_n) w_fifo_empty == empty);

endmodule

// File: tb/tb_fifo_arbiter.sv
// Directed and randomized checks of fifo_arbiter against a queue-based reference.
module tb_fifo_arbiter;
    import fifo_arbiter_pkg::*;

    localparam int NUM_REQ = 4;
    localparam int DW      = 16;
    localparam int AW      = 3;
    localparam int DEPTH   = 8;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*DW-1:0] req_data;
    logic [NUM_REQ-1:0]    gnt;
    logic                  rd;
    logic [DW-1:0]         r_data;
    logic                  empty;
    logic                  full;
    logic [AW:0]           count;
    logic                  err_underflow;

    fifo_arbiter #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req           (req),
        .req_data      (req_data),
        .gnt           (gnt),
        .rd            (rd),
        .r_data        (r_data),
        .empty         (empty),
        .full          (full),
        .count         (count),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] word [NUM_REQ];
    logic [DW-1:0] q [$];
    int            m_ptr;
    logic          m_err;
    int            n_vec = 0;
    int            n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, check grant/head before the edge, update model, check state after.
    task automatic cycle(input logic [NUM_REQ-1:0] rq, input logic rdv, output int g);
        int   win;
        logic rd_ok;
        logic wr_ok;
        req = rq;
        rd  = rdv;
        for (int i = 0; i < NUM_REQ; i++) req_data[i*DW +: DW] = word[i];
        #2;
        rd_ok = rdv && (q.size() > 0);
        wr_ok = (q.size() < DEPTH) || rd_ok;
        win = -1;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx = (m_ptr + k) % NUM_REQ;
            if (win < 0 && rq[idx]) win = idx;
        end
        g = (wr_ok && win >= 0) ? win : -1;
        chk("gnt", 32'(gnt), (g >= 0) ? (32'd1 << g) : 32'd0);
        if (q.size() > 0) chk("r_data", 32'(r_data), 32'(q[0]));
        @(posedge clk);
        #1;
        if (rdv && q.size() == 0) m_err = 1'b1;
        if (rd_ok) void'(q.pop_front());
        if (g >= 0) begin
            q.push_back(word[g]);
            m_ptr = (g + 1) % NUM_REQ;
        end
        chk("count", 32'(count), 32'(q.size()));
        chk("empty", 32'(empty), 32'(q.size() == 0));
        chk("full", 32'(full), 32'(q.size() == DEPTH));
        chk("err_underflow", 32'(err_underflow), 32'(m_err));
        $display("cycle req=%b rd=%b gnt=%b count=%0d head=%h err=%b",
                 rq, rdv, gnt, count, r_data, err_underflow);
    endtask

    initial begin
        int     g;
        int     exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
        int     t4_order  [3] = '{3, 0, 3};
        logic   pend      [NUM_REQ];
        int     wait_cnt  [NUM_REQ];
        count_t peak;

        reset_n  = 1'b0;
        req      = 4'b1111;
        rd       = 1'b0;
        req_data = '0;
        for (int i = 0; i < NUM_REQ; i++) word[i] = 16'hA000 + 16'(i);
        #3;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_err", 32'(err_underflow), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_ptr = 0;
        m_err = 1'b0;

        // Fill from four producers, then one extra cycle while full.
        for (int c = 0; c < 8; c++) begin
            cycle(4'b1111, 1'b0, g);
            chk("t1_order", 32'(g), 32'(exp_order[c]));
        end
        cycle(4'b1111, 1'b0, g);
        chk("t1_stall", 32'(g), 32'hFFFF_FFFF);
        chk("t1_count", 32'(count), 32'd8);

        // Drain past empty.
        for (int c = 0; c < 9; c++) cycle(4'b0000, 1'b1, g);
        chk("t2_err", 32'(err_underflow), 32'd1);
        chk("t2_empty", 32'(empty), 32'd1);

        // Refill, then write+pop together while full.
        for (int c = 0; c < 8; c++) cycle(4'b1111, 1'b0, g);
        for (int i = 0; i < NUM_REQ; i++) word[i] = 16'hB000 + 16'(i);
        for (int c = 0; c < 3; c++) begin
            cycle(4'b0100, 1'b1, g);
            chk("t3_gnt", 32'(g), 32'd2);
            chk("t3_count", 32'(count), 32'd8);
        end

        // Wrap: pointer sits at 3 after the last grant to producer 2.
        for (int c = 0; c < 3; c++) begin
            cycle(4'b1001, 1'b1, g);
            chk("t4_wrap", 32'(g), 32'(t4_order[c]));
        end

        // Drain, write three words, then pulse reset mid-cycle.
        for (int c = 0; c < 8; c++) cycle(4'b0000, 1'b1, g);
        for (int c = 0; c < 3; c++) cycle(4'b1111, 1'b0, g);
        req = 4'b1010;
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_count", 32'(count), 32'd0);
        chk("t5_empty", 32'(empty), 32'd1);
        chk("t5_full", 32'(full), 32'd0);
        chk("t5_err", 32'(err_underflow), 32'd0);
        chk("t5_gnt", 32'(gnt), 32'd0);
        #2;
        reset_n = 1'b1;
        q.delete();
        m_ptr = 0;
        m_err = 1'b0;
        cycle(4'b1010, 1'b0, g);
        chk("t5_first", 32'(g), 32'd1);

        // Randomized traffic; producers hold req until granted.
        for (int i = 0; i < NUM_REQ; i++) begin
            pend[i]     = (i == 3);
            wait_cnt[i] = 0;
        end
        peak = '0;
        for (int c = 0; c < 2000; c++) begin
            logic [NUM_REQ-1:0] rq;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
                    pend[i] = 1'b1;
                    word[i] = 16'($urandom);
                end
                rq[i] = pend[i];
            end
            cycle(rq, ($urandom_range(0, 99) < 45), g);
            if (count > peak) peak = count;
            if (g >= 0) begin
                n_vec++;
                assert (wait_cnt[g] <= NUM_REQ - 1) else begin
                    n_bad++;
                    $error("FAIL fairness: producer %0d waited %0d grants, limit %0d",
                           g, wait_cnt[g], NUM_REQ - 1);
                end
                for (int i = 0; i < NUM_REQ; i++)
                    if (i != g && pend[i]) wait_cnt[i]++;
                pend[g]     = 1'b0;
                wait_cnt[g] = 0;
            end
        end
        $display("random phase peak occupancy %0d", peak);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
